// File: rtl/display_status_arbiter.sv
// Scan pacing and frame-aligned arbitration of the 12-bit status path between game and message sources.
// Optional frame blinking of message snapshots is compiled in with `define DISP_BLINK_EN.
module display_status_arbiter #(
    parameter int REFRESH_DIV  = 4,
    parameter int HOLD_FRAMES  = 2,
    parameter int BLINK_FRAMES = 8
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [11:0] game_status,
    input  logic [11:0] msg_status,
    input  logic        msg_req,
    output logic        msg_ack,
    output logic        scan_tick,
    output logic [1:0]  digit_idx,
    output logic        frame_start,
    output logic [11:0] status_out,
    output logic        owner
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);

    localparam logic [1:0] ST_GAME = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [DW-1:0] div_cnt_q,   div_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [1:0]    state_q,     state_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic [11:0]   status_q,    status_d;
    logic          owner_q,     owner_d;
    logic          ack_s;
    logic          show_msg_s;
    logic          entering_show_s;
    logic [11:0]   msg_view_s;

    // Prescaler decode and scan position.
    always_comb begin
        scan_tick   = (div_cnt_q == DIV_LAST);
        frame_start = scan_tick && (digit_idx_q == 2'd3);
        div_cnt_d   = scan_tick ? '0 : div_cnt_q + DW'(1);
        digit_idx_d = scan_tick ? digit_idx_q + 2'd1 : digit_idx_q;
    end

    // Grant FSM; the ack is a Mealy pulse on the frame that completes the hold.
    always_comb begin
        state_d = state_q;
        ack_s   = 1'b0;
        case (state_q)
            ST_GAME: begin
                if (msg_req) begin
                    state_d = frame_start ? ST_SHOW : ST_PEND;
                end else begin
                    state_d = ST_GAME;
                end
            end
            ST_PEND: begin
                if (!msg_req) begin
                    state_d = ST_GAME;
                end else if (frame_start) begin
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_SHOW: begin
                if (!msg_req) begin
                    state_d = ST_GAME;
                end else if (frame_start && (hold_cnt_q == HOLD_LAST)) begin
                    ack_s   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_DONE: begin
                if (!msg_req) begin
                    state_d = ST_GAME;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_GAME;
            end
        endcase
    end

    // Hold counter is held at zero outside SHOW so every entry starts from a clean count.
    always_comb begin
        if (state_q != ST_SHOW) begin
            hold_cnt_d = '0;
        end else if (frame_start && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    assign show_msg_s      = (state_d == ST_SHOW) || (state_d == ST_DONE);
    assign entering_show_s = frame_start && (state_d == ST_SHOW) && (state_q != ST_SHOW);

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    // Blink phase advances once per message frame and restarts visible on each grant.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (entering_show_s) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (frame_start && show_msg_s && owner_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
        msg_view_s = blink_off_d ? 12'h000 : msg_status;
    end

    // Blink state registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    assign msg_view_s = msg_status;
`endif

    // Snapshot is only taken on frame boundaries so a frame never mixes sources.
    always_comb begin
        if (frame_start) begin
            owner_d  = show_msg_s;
            status_d = show_msg_s ? msg_view_s : game_status;
        end else begin
            owner_d  = owner_q;
            status_d = status_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 2'd0;
            state_q     <= ST_GAME;
            hold_cnt_q  <= '0;
            status_q    <= 12'h000;
            owner_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            status_q    <= status_d;
            owner_q     <= owner_d;
        end
    end

    assign msg_ack    = ack_s;
    assign digit_idx  = digit_idx_q;
    assign status_out = status_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_display_status_arbiter.sv
// Bench for display_status_arbiter: directed scenarios with literal checkpoints, then random traffic vs a grant model.
module tb_display_status_arbiter;

    localparam int R    = 4;
    localparam int HOLD = 2;
    localparam int FR   = 4 * R;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] game_status = 12'h000;
    logic [11:0] msg_status = 12'h000;
    logic        msg_req = 1'b0;
    logic        msg_ack;
    logic        scan_tick;
    logic [1:0]  digit_idx;
    logic        frame_start;
    logic [11:0] status_out;
    logic        owner;

    display_status_arbiter #(.REFRESH_DIV(R), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(8)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .game_status(game_status),
        .msg_status(msg_status), .msg_req(msg_req), .msg_ack(msg_ack),
        .scan_tick(scan_tick), .digit_idx(digit_idx), .frame_start(frame_start),
        .status_out(status_out), .owner(owner)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;
    int scen   = 0;

    // Model state: cycle index since reset release and an abstract grant record.
    int          n_m = 0;
    bit          granted = 1'b0;
    bit          acked = 1'b0;
    int          frames = 0;
    logic [11:0] exp_status = 12'h000;
    logic        exp_owner = 1'b0;
    int          ack_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n_m, act, exp);
        else passed++;
    endtask

    // Compare process: sample away from the active edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!reset_n) begin
                chk("rst_scan_tick", {31'd0, scan_tick}, 32'd0);
                chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
                chk("rst_digit_idx", {30'd0, digit_idx}, 32'd0);
                chk("rst_msg_ack", {31'd0, msg_ack}, 32'd0);
                chk("rst_status_out", {20'd0, status_out}, 32'd0);
                chk("rst_owner", {31'd0, owner}, 32'd0);
                n_m = 0; granted = 1'b0; acked = 1'b0; frames = 0;
                exp_status = 12'h000; exp_owner = 1'b0;
            end else begin
                bit fs_m, tick_m, ack_m;
                fs_m   = (n_m % FR) == FR - 1;
                tick_m = (n_m % R) == R - 1;
                ack_m  = msg_req && granted && !acked && fs_m && (frames + 1 == HOLD);
                chk("scan_tick", {31'd0, scan_tick}, {31'd0, tick_m});
                chk("digit_idx", {30'd0, digit_idx}, 32'((n_m / R) % 4));
                chk("frame_start", {31'd0, frame_start}, {31'd0, fs_m});
                chk("msg_ack", {31'd0, msg_ack}, {31'd0, ack_m});
                chk("status_out", {20'd0, status_out}, {20'd0, exp_status});
                chk("owner", {31'd0, owner}, {31'd0, exp_owner});
                if (msg_ack === 1'b1) ack_count++;

                // Hand-computed checkpoints for the directed scenarios.
                if (scen == 1) begin
                    if (n_m == 3)  chk("lit_tick3", {31'd0, scan_tick}, 32'd1);
                    if (n_m == 14) chk("lit_pre_frame", {20'd0, status_out}, 32'h000);
                    if (n_m == 15) chk("lit_fs15", {31'd0, frame_start}, 32'd1);
                    if (n_m == 16) chk("lit_game16", {20'd0, status_out}, 32'hABC);
                    if (n_m == 32) chk("lit_msg32", {19'd0, owner, status_out}, 32'h1111);
                    if (n_m == 47) chk("lit_noack47", {31'd0, msg_ack}, 32'd0);
                    if (n_m == 63) chk("lit_ack63", {31'd0, msg_ack}, 32'd1);
                    if (n_m == 64) chk("lit_hold64", {19'd0, owner, status_out}, 32'h1111);
                    if (n_m == 80) chk("lit_game80", {19'd0, owner, status_out}, 32'h0ABC);
                    if (n_m == 89) chk("lit_one_ack", 32'(ack_count), 32'd1);
                end
                if (scen == 4) begin
                    if (n_m == 48) chk("lit_abort_show48", {19'd0, owner, status_out}, 32'h1222);
                    if (n_m == 64) chk("lit_abort_game64", {19'd0, owner, status_out}, 32'h0ABC);
                end
                if (scen == 5) begin
                    if (n_m == 16) chk("lit_direct16", {19'd0, owner, status_out}, 32'h15A5);
                end

                if (!msg_req) begin
                    granted = 1'b0; acked = 1'b0; frames = 0;
                end else if (!granted) begin
                    if (fs_m) begin granted = 1'b1; acked = 1'b0; frames = 0; end
                end else if (fs_m && !acked) begin
                    frames++;
                    if (frames == HOLD) acked = 1'b1;
                end
                if (fs_m) begin
                    exp_owner  = granted;
                    exp_status = granted ? msg_status : game_status;
                end
                n_m++;
            end
        end
    end

    int cyc = 0;

    task automatic go(input int k);
        while (cyc < k) begin
            @(posedge clk_in); #1;
            cyc++;
        end
    endtask

    task automatic restart(input int s);
        @(posedge clk_in); #1;
        reset_n = 1'b0;
        msg_req = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        scen = s;
        game_status = 12'hABC;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int left;
        left = 0;

        restart(1);
        go(20);  msg_status = 12'h111; msg_req = 1'b1;
        go(70);  msg_req = 1'b0;
        go(92);

        restart(4);
        go(35);  msg_status = 12'h222; msg_req = 1'b1;
        go(50);  msg_req = 1'b0;
        go(80);

        restart(5);
        go(15);  msg_status = 12'h5A5; msg_req = 1'b1;
        go(40);
        restart(0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_in); #1;
            if ($urandom_range(0, 7) == 0) game_status = 12'($urandom);
            if (msg_req) begin
                if (left == 0) msg_req = 1'b0;
                else left--;
            end else if ($urandom_range(0, 19) == 0) begin
                msg_status = 12'($urandom);
                msg_req = 1'b1;
                left = $urandom_range(0, 90);
            end
            if ($urandom_range(0, 1499) == 0) restart(0);
        end
        repeat (2) @(negedge clk_in);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
